// File: rtl/hdmi_mon_pkg.sv
// Shared constants, types and the bytewise reflected CRC-32 step for the HDMI stream monitors.
package hdmi_mon_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT    = 32'hFFFFFFFF;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned POS_W = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Pixel payload as carried on tdata: b0 is the first byte on the wire.
    typedef struct packed {
        logic [7:0] b2;
        logic [7:0] b1;
        logic [7:0] b0;
    } pixel_t;

    // One byte of CRC-32 IEEE in reflected form, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/hdmi_stream_crc_monitor_crc32_px24.sv
// Combinational CRC-32 step over one 24-bit pixel (byte0, byte1, byte2 in that order).
module crc32_px24
    import hdmi_mon_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [23:0] px,
    output logic [31:0] crc_out
);

    pixel_t      pix;
    logic [31:0] crc_b0;
    logic [31:0] crc_b1;

    always_comb begin
        pix     = pixel_t'(px);
        crc_b0  = crc32_byte(crc_in, pix.b0);
        crc_b1  = crc32_byte(crc_b0, pix.b1);
        crc_out = crc32_byte(crc_b1, pix.b2);
    end

endmodule

// File: rtl/hdmi_stream_crc_monitor.sv
// Sink-side monitor for the 24-bit video AXI-Stream: framing checks, per-frame CRC-32 and counters.
module hdmi_stream_crc_monitor
    import hdmi_mon_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = 32,
    parameter int unsigned SCREEN_HEIGHT = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [23:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    output logic             s_axis_tready,
    input  logic             sink_ready_en,
    input  logic             stats_clear,
    output logic [CNT_W-1:0] beat_count,
    output logic [CNT_W-1:0] frame_count,
    output logic [31:0]      crc_last,
    output logic [POS_W-1:0] line_count,
    output logic [POS_W-1:0] pixel_in_line,
    output logic             frame_done,
    output logic             err_sof_early,
    output logic             err_line_len,
    output logic             err_no_sof
);

    localparam logic [POS_W-1:0] LAST_PIX  = POS_W'(SCREEN_WIDTH - 1);
    localparam logic [POS_W-1:0] LAST_LINE = POS_W'(SCREEN_HEIGHT - 1);
    localparam logic [POS_W-1:0] POS_MAX   = '1;

    state_t           state_q;
    state_t           state_d;
    logic [31:0]      crc_q;
    logic [31:0]      crc_d;
    logic             frame_bad_q;
    logic             frame_bad_d;

    logic [CNT_W-1:0] beat_d;
    logic [CNT_W-1:0] frame_cnt_d;
    logic [31:0]      crc_last_d;
    logic [POS_W-1:0] line_d;
    logic [POS_W-1:0] pix_d;
    logic             frame_done_d;
    logic             err_sof_d;
    logic             err_len_d;
    logic             err_nosof_d;

    logic             accept;
    logic [31:0]      crc_seed;
    logic [31:0]      crc_upd;
    logic [POS_W-1:0] line_eff;
    logic [POS_W-1:0] pix_eff;
    logic             line_err;
    logic             frame_bad_nx;

    assign accept = s_axis_tvalid & s_axis_tready;

    // A tuser beat always starts a fresh frame, so it seeds from init; in IDLE crc_q already holds init.
    assign crc_seed = s_axis_tuser ? CRC32_INIT : crc_q;

    crc32_px24 u_crc (
        .crc_in  (crc_seed),
        .px      (s_axis_tdata),
        .crc_out (crc_upd)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        frame_bad_d  = frame_bad_q;
        beat_d       = beat_count;
        frame_cnt_d  = frame_count;
        crc_last_d   = crc_last;
        line_d       = line_count;
        pix_d        = pixel_in_line;
        frame_done_d = 1'b0;
        err_sof_d    = err_sof_early;
        err_len_d    = err_line_len;
        err_nosof_d  = err_no_sof;

        // Position as seen by this beat; a tuser beat is pixel 0 of line 0.
        line_eff     = s_axis_tuser ? '0 : line_count;
        pix_eff      = s_axis_tuser ? '0 : pixel_in_line;
        line_err     = s_axis_tlast && (pix_eff != LAST_PIX);
        frame_bad_nx = (s_axis_tuser ? 1'b0 : frame_bad_q) | line_err;

        if (accept) begin
            beat_d = beat_count + CNT_W'(1);
            if ((state_q == IDLE) && !s_axis_tuser) begin
                err_nosof_d = 1'b1;
            end else begin
                if ((state_q == ACTIVE) && s_axis_tuser) begin
                    err_sof_d = 1'b1;
                end
                if (line_err) begin
                    err_len_d = 1'b1;
                end
                state_d     = ACTIVE;
                crc_d       = crc_upd;
                frame_bad_d = frame_bad_nx;

                if (!s_axis_tlast) begin
                    line_d = line_eff;
                    pix_d  = (pix_eff == POS_MAX) ? pix_eff : pix_eff + POS_W'(1);
                end else if (line_eff < LAST_LINE) begin
                    line_d = line_eff + POS_W'(1);
                    pix_d  = '0;
                end else begin
                    // Frame end: publish the CRC even for a malformed frame, count only clean ones.
                    state_d      = IDLE;
                    crc_d        = CRC32_INIT;
                    frame_bad_d  = 1'b0;
                    line_d       = '0;
                    pix_d        = '0;
                    crc_last_d   = crc_upd ^ CRC32_XOROUT;
                    frame_done_d = 1'b1;
                    if (!frame_bad_nx) begin
                        frame_cnt_d = frame_count + CNT_W'(1);
                    end
                end
            end
        end

        if (stats_clear) begin
            beat_d      = '0;
            frame_cnt_d = '0;
            crc_last_d  = '0;
            err_sof_d   = 1'b0;
            err_len_d   = 1'b0;
            err_nosof_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            crc_q         <= CRC32_INIT;
            frame_bad_q   <= 1'b0;
            s_axis_tready <= 1'b0;
            beat_count    <= '0;
            frame_count   <= '0;
            crc_last      <= '0;
            line_count    <= '0;
            pixel_in_line <= '0;
            frame_done    <= 1'b0;
            err_sof_early <= 1'b0;
            err_line_len  <= 1'b0;
            err_no_sof    <= 1'b0;
        end else begin
            state_q       <= state_d;
            crc_q         <= crc_d;
            frame_bad_q   <= frame_bad_d;
            s_axis_tready <= sink_ready_en;
            beat_count    <= beat_d;
            frame_count   <= frame_cnt_d;
            crc_last      <= crc_last_d;
            line_count    <= line_d;
            pixel_in_line <= pix_d;
            frame_done    <= frame_done_d;
            err_sof_early <= err_sof_d;
            err_line_len  <= err_len_d;
            err_no_sof    <= err_nosof_d;
        end
    end

endmodule

// File: tb/tb_hdmi_stream_crc_monitor.sv
// Directed bench: a 32x24 monitor checked every cycle against a frame-level model, plus a 3x1 instance.
module tb_hdmi_stream_crc_monitor;

    localparam int W = 32;
    localparam int H = 24;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] tdata;
    logic        tvalid_a, tvalid_b, tuser, tlast;
    logic        sink_ready_en, stats_clear;

    logic        tready_a, done_a, esof_a, elen_a, enosof_a;
    logic [31:0] beat_a, frames_a, crc_a;
    logic [15:0] line_a, pix_a;
    logic        tready_b, done_b, esof_b, elen_b, enosof_b;
    logic [31:0] beat_b, frames_b, crc_b;
    logic [15:0] line_b, pix_b;

    always #5 clk = ~clk;

    hdmi_stream_crc_monitor #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid_a),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser), .s_axis_tready(tready_a),
        .sink_ready_en(sink_ready_en), .stats_clear(stats_clear), .beat_count(beat_a),
        .frame_count(frames_a), .crc_last(crc_a), .line_count(line_a), .pixel_in_line(pix_a),
        .frame_done(done_a), .err_sof_early(esof_a), .err_line_len(elen_a), .err_no_sof(enosof_a)
    );

    hdmi_stream_crc_monitor #(.SCREEN_WIDTH(3), .SCREEN_HEIGHT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid_b),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser), .s_axis_tready(tready_b),
        .sink_ready_en(sink_ready_en), .stats_clear(stats_clear), .beat_count(beat_b),
        .frame_count(frames_b), .crc_last(crc_b), .line_count(line_b), .pixel_in_line(pix_b),
        .frame_done(done_b), .err_sof_early(esof_b), .err_line_len(elen_b), .err_no_sof(enosof_b)
    );

    int          total = 0;
    int          bad = 0;
    bit          chk_en = 0;
    bit          stall = 0;
    int          done_cnt_a = 0;
    int          done_cnt_b = 0;
    logic [7:0]  sent[$];
    logic [31:0] clean_crc;

    // Frame-level model of dut_a: position in plain integers, CRC over the collected frame bytes.
    logic        m_tready, m_done, m_esof, m_elen, m_enosof;
    logic [31:0] m_beat, m_frames, m_crc;
    int          m_line, m_pix;
    bit          m_active, m_bad;
    logic [7:0]  m_bytes[$];

    function automatic logic [31:0] crc_ref(input logic [7:0] q[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic logic [23:0] px(input int l, input int p);
        return {8'(l * 5 + p), 8'(p), 8'(l)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit acc;
        bit done;
        if (!rst_n) begin
            m_tready = 0; m_beat = 0; m_frames = 0; m_crc = 0; m_done = 0;
            m_line = 0; m_pix = 0; m_esof = 0; m_elen = 0; m_enosof = 0;
            m_active = 0; m_bad = 0; m_bytes.delete();
            return;
        end
        acc  = tvalid_a && m_tready;
        done = 0;
        if (acc) begin
            m_beat = m_beat + 32'd1;
            if (!m_active && !tuser) begin
                m_enosof = 1;
            end else begin
                if (tuser) begin
                    if (m_active) m_esof = 1;
                    m_bytes.delete();
                    m_line = 0; m_pix = 0; m_bad = 0; m_active = 1;
                end
                m_bytes.push_back(tdata[7:0]);
                m_bytes.push_back(tdata[15:8]);
                m_bytes.push_back(tdata[23:16]);
                if (tlast) begin
                    if (m_pix != W - 1) begin m_elen = 1; m_bad = 1; end
                    if (m_line == H - 1) begin
                        m_crc = crc_ref(m_bytes);
                        done = 1;
                        if (!m_bad) m_frames = m_frames + 32'd1;
                        m_line = 0; m_pix = 0; m_active = 0;
                        m_bytes.delete();
                    end else begin
                        m_line++; m_pix = 0;
                    end
                end else if (m_pix < 65535) begin
                    m_pix++;
                end
            end
        end
        if (stats_clear) begin
            m_beat = 0; m_frames = 0; m_crc = 0; m_esof = 0; m_elen = 0; m_enosof = 0;
        end
        m_tready = sink_ready_en;
        m_done   = done;
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("tready", 32'(tready_a), 32'(m_tready));
                check("beat_count", beat_a, m_beat);
                check("frame_count", frames_a, m_frames);
                check("crc_last", crc_a, m_crc);
                check("line_count", 32'(line_a), 32'(m_line));
                check("pixel_in_line", 32'(pix_a), 32'(m_pix));
                check("frame_done", 32'(done_a), 32'(m_done));
                check("err_sof_early", 32'(esof_a), 32'(m_esof));
                check("err_line_len", 32'(elen_a), 32'(m_elen));
                check("err_no_sof", 32'(enosof_a), 32'(m_enosof));
            end
            if (done_a === 1'b1) done_cnt_a++;
            if (done_b === 1'b1) done_cnt_b++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (stall) sink_ready_en = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_beat(input logic [23:0] d, input logic u, input logic l, input bit to_b);
        bit acc;
        int n;
        tdata = d; tuser = u; tlast = l;
        tvalid_a = !to_b; tvalid_b = to_b;
        acc = 0; n = 0;
        while (!acc) begin
            @(negedge clk);
            acc = to_b ? tready_b : tready_a;
            tick();
            if (!acc) begin
                n++;
                if (n >= 100) begin
                    total++; bad++;
                    $display("FAIL beat_timeout: got no handshake want handshake within 100 cycles");
                    break;
                end
            end
        end
        sent.push_back(d[7:0]); sent.push_back(d[15:8]); sent.push_back(d[23:16]);
        tvalid_a = 0; tvalid_b = 0; tuser = 0; tlast = 0;
    endtask

    task automatic send_frame(input bit gaps);
        for (int l = 0; l < H; l++) begin
            for (int p = 0; p < W; p++) begin
                if (gaps) repeat ($urandom_range(0, 2)) tick();
                send_beat(px(l, p), (l == 0) && (p == 0), p == W - 1, 0);
            end
        end
    endtask

    task automatic pulse_clear();
        stats_clear = 1;
        tick();
        stats_clear = 0;
    endtask

    initial begin
        logic [7:0] q[$];
        int         d0;
        rst_n = 0; tdata = 0; tvalid_a = 0; tvalid_b = 0; tuser = 0; tlast = 0;
        sink_ready_en = 0; stats_clear = 0;

        fork
            forever begin @(posedge clk); model_step(); end
            compare_loop();
            begin
                #2000000;
                $display("FAIL watchdog: got time limit want self-termination");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Pin the model CRC to the standard check value of "123456789".
        for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
        check("model_crc_pin", crc_ref(q), 32'hCBF43926);
        q.delete();
        for (int l = 0; l < H; l++)
            for (int p = 0; p < W; p++) begin
                logic [23:0] v;
                v = px(l, p);
                q.push_back(v[7:0]); q.push_back(v[15:8]); q.push_back(v[23:16]);
            end
        clean_crc = crc_ref(q);

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1;
        check("reset_beat", beat_a, 32'd0);
        check("reset_tready", 32'(tready_a), 32'd0);
        rst_n = 1;
        sink_ready_en = 1;
        tick(); tick();

        // 3x1 instance: "123456789" as three pixels.
        send_beat(24'h333231, 1, 0, 1);
        send_beat(24'h363534, 0, 0, 1);
        send_beat(24'h393837, 0, 1, 1);
        tick();
        check("small_crc", crc_b, 32'hCBF43926);
        check("small_frames", frames_b, 32'd1);
        check("small_beats", beat_b, 32'd3);
        check("small_done_pulses", 32'(done_cnt_b), 32'd1);
        check("small_errs", {29'd0, esof_b, elen_b, enosof_b}, 32'd0);
        check("small_pos", {line_b, pix_b}, 32'd0);

        // Two back-to-back clean frames.
        send_frame(0);
        check("f1_crc", crc_a, clean_crc);
        check("f1_frames", frames_a, 32'd1);
        send_frame(0);
        tick();
        check("f2_crc", crc_a, clean_crc);
        check("f2_frames", frames_a, 32'd2);
        check("f2_beats", beat_a, 32'd1536);
        check("f2_pos", {line_a, pix_a}, 32'd0);
        check("f2_done_pulses", 32'(done_cnt_a), 32'd2);

        // Same frames under backpressure and valid gaps.
        pulse_clear();
        stall = 1;
        send_frame(1);
        send_frame(1);
        stall = 0;
        sink_ready_en = 1;
        tick();
        check("stall_crc", crc_a, clean_crc);
        check("stall_beats", beat_a, 32'd1536);
        check("stall_frames", frames_a, 32'd2);

        // Short line: tlast at pixel 10 of line 5.
        pulse_clear();
        sent.delete();
        d0 = done_cnt_a;
        for (int l = 0; l < H; l++) begin
            int plen;
            plen = (l == 5) ? 11 : W;
            for (int p = 0; p < plen; p++)
                send_beat(px(l, p), (l == 0) && (p == 0), p == plen - 1, 0);
            if (l == 5) begin
                check("short_err", 32'(elen_a), 32'd1);
                check("short_next_line", 32'(line_a), 32'd6);
                check("short_next_pix", 32'(pix_a), 32'd0);
            end
        end
        tick();
        check("short_frames", frames_a, 32'd0);
        check("short_crc", crc_a, crc_ref(sent));
        check("short_done", 32'(done_cnt_a - d0), 32'd1);

        // Early SOF in line 3, then a full frame from that SOF.
        pulse_clear();
        for (int i = 0; i < 3 * W + 5; i++)
            send_beat(px(i / W, i % W), i == 0, (i % W) == W - 1, 0);
        send_frame(0);
        tick();
        check("sof_err", 32'(esof_a), 32'd1);
        check("sof_frames", frames_a, 32'd1);
        check("sof_crc", crc_a, clean_crc);
        pulse_clear();
        check("clr_beats", beat_a, 32'd0);
        check("clr_frames", frames_a, 32'd0);
        check("clr_crc", crc_a, 32'd0);
        check("clr_errs", {29'd0, esof_a, elen_a, enosof_a}, 32'd0);

        // Beats without SOF, then reset in the middle of a frame.
        for (int i = 0; i < 5; i++) send_beat(px(0, i), 0, 0, 0);
        check("nosof_err", 32'(enosof_a), 32'd1);
        check("nosof_beats", beat_a, 32'd5);
        check("nosof_pos", {line_a, pix_a}, 32'd0);
        for (int i = 0; i < 40; i++)
            send_beat(px(i / W, i % W), i == 0, (i % W) == W - 1, 0);
        check("mid_line", 32'(line_a), 32'd1);
        check("mid_pix", 32'(pix_a), 32'd8);
        d0 = done_cnt_a;
        rst_n = 0;
        tick(); tick();
        check("rst_beats", beat_a, 32'd0);
        check("rst_errs", {29'd0, esof_a, elen_a, enosof_a}, 32'd0);
        check("rst_pos", {line_a, pix_a}, 32'd0);
        check("rst_tready", 32'(tready_a), 32'd0);
        rst_n = 1;
        tick();
        send_frame(0);
        tick();
        check("post_rst_frames", frames_a, 32'd1);
        check("post_rst_crc", crc_a, clean_crc);
        check("post_rst_beats", beat_a, 32'd768);
        check("post_rst_done", 32'(done_cnt_a - d0), 32'd1);

        tick();
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
